// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// Shared types and sizing helpers for the IJTAG data mux TDR and its select sequencer.
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

   typedef enum logic [1:0] {
      FUNC   = 2'd0,
      ARM_IJ = 2'd1,
      IJTAG  = 2'd2,
      ARM_FN = 2'd3
   } sw_state_t;

   localparam int DW_DEFAULT           = 19;
   localparam int SWITCH_DELAY_DEFAULT = 4;

   // The scan register carries the select request bit above the data word.
   function automatic int sr_width(input int dw);
      return dw + 1;
   endfunction

   function automatic int cnt_width(input int delay);
      return (delay < 2) ? 1 : $clog2(delay + 1);
   endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_switch_seq.sv
// Select switch-over sequencer: holds the mux select steady for a settle delay after
// each request change and lets a reverted request abort the pending switch.
module firebird7_in_gate1_tessent_data_mux_switch_seq
   import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
   parameter int SWITCH_DELAY = SWITCH_DELAY_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic req_sel,
   output logic sel,
   output logic busy
);

   localparam int CW = cnt_width(SWITCH_DELAY);
   localparam logic [CW-1:0] CNT_LOAD = (SWITCH_DELAY == 0) ? '0 : CW'(SWITCH_DELAY - 1);

   sw_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sel_q, sel_d;
   logic            busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         FUNC: begin
            if (req_sel) begin
               if (SWITCH_DELAY == 0) begin
                  state_d = IJTAG;
               end else begin
                  state_d = ARM_IJ;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ARM_IJ: begin
            if (!req_sel) begin
               state_d = FUNC;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = IJTAG;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         IJTAG: begin
            if (!req_sel) begin
               if (SWITCH_DELAY == 0) begin
                  state_d = FUNC;
               end else begin
                  state_d = ARM_FN;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ARM_FN: begin
            if (req_sel) begin
               state_d = IJTAG;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = FUNC;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = FUNC;
            cnt_d   = '0;
         end
      endcase
      // Decode from the next state so both outputs leave a flop directly.
      sel_d  = (state_d == IJTAG)  || (state_d == ARM_FN);
      busy_d = (state_d == ARM_IJ) || (state_d == ARM_FN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FUNC;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign sel  = sel_q;
   assign busy = busy_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG TDR for the 19-bit data mux: capture/shift/update of a {select, data} word,
// with the select change handed to the settle sequencer.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19
   import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = DW_DEFAULT,
   parameter int SWITCH_DELAY = SWITCH_DELAY_DEFAULT
) (
   input  logic                  ijtag_tck,
   input  logic                  ijtag_reset,
   input  logic                  ijtag_sel,
   input  logic                  ijtag_ce,
   input  logic                  ijtag_se,
   input  logic                  ijtag_ue,
   input  logic                  ijtag_si,
   output logic                  ijtag_so,
   input  logic [DATA_WIDTH-1:0] mux_data_out,
   output logic                  mux_ijtag_select,
   output logic [DATA_WIDTH-1:0] mux_ijtag_data_in,
   output logic                  switch_busy
);

   localparam int SRW = sr_width(DATA_WIDTH);

   logic [SRW-1:0]        sr_q, sr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  req_sel_q, req_sel_d;
   logic                  sel_w;
   logic                  busy_w;

   always_comb begin
      sr_d      = sr_q;
      data_d    = data_q;
      req_sel_d = req_sel_q;
      // Capture wins over shift, shift over update; nothing moves while deselected.
      if (ijtag_sel) begin
         if (ijtag_ce) begin
            sr_d = {sel_w, mux_data_out};
         end else if (ijtag_se) begin
            sr_d = {ijtag_si, sr_q[SRW-1:1]};
         end else if (ijtag_ue) begin
            data_d    = sr_q[DATA_WIDTH-1:0];
            req_sel_d = sr_q[DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
      if (ijtag_reset) begin
         sr_q      <= '0;
         data_q    <= '0;
         req_sel_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         data_q    <= data_d;
         req_sel_q <= req_sel_d;
      end
   end

   firebird7_in_gate1_tessent_data_mux_switch_seq #(
      .SWITCH_DELAY (SWITCH_DELAY)
   ) u_switch_seq (
      .clk     (ijtag_tck),
      .rst     (ijtag_reset),
      .req_sel (req_sel_q),
      .sel     (sel_w),
      .busy    (busy_w)
   );

   assign ijtag_so          = sr_q[0];
   assign mux_ijtag_select  = sel_w;
   assign mux_ijtag_data_in = data_q;
   assign switch_busy       = busy_w;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Directed bench for the IJTAG data mux TDR: vector table plus hand-written switch sequences,
// with a second zero-delay instance sharing the same stimulus.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

   logic        tck = 1'b0;
   logic        rst, tsel, ce, se, ue, si;
   logic [18:0] mdo;
   logic        so, msel, busy;
   logic [18:0] mdin;
   logic        so0, msel0, busy0;
   logic [18:0] mdin0;
   logic        busy0_seen = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 tck = ~tck;

   firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(.DATA_WIDTH(19), .SWITCH_DELAY(4)) dut (
      .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(tsel), .ijtag_ce(ce), .ijtag_se(se),
      .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so), .mux_data_out(mdo),
      .mux_ijtag_select(msel), .mux_ijtag_data_in(mdin), .switch_busy(busy));

   firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(.DATA_WIDTH(19), .SWITCH_DELAY(0)) dut0 (
      .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(tsel), .ijtag_ce(ce), .ijtag_se(se),
      .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so0), .mux_data_out(mdo),
      .mux_ijtag_select(msel0), .mux_ijtag_data_in(mdin0), .switch_busy(busy0));

   always @(posedge tck) if (busy0) busy0_seen <= 1'b1;

   typedef struct {
      logic        ts;
      logic [19:0] word;
      logic [18:0] exp_data;
      logic        exp_so;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge tck);
      @(negedge tck);
   endtask

   task automatic shift_word(input logic ts, input logic [19:0] w);
      tsel = ts;
      se   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         si = w[i];
         step();
      end
      se   = 1'b0;
      si   = 1'b0;
      tsel = 1'b1;
   endtask

   task automatic update(input logic ts);
      tsel = ts;
      ue   = 1'b1;
      step();
      ue   = 1'b0;
      tsel = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [19:0] w;
      logic [19:0] exp20;

      vecs[0] = '{1'b1, 20'h00001, 19'h00001, 1'b1};
      vecs[1] = '{1'b1, 20'h40000, 19'h40000, 1'b0};
      vecs[2] = '{1'b0, 20'h7FFFF, 19'h40000, 1'b0};
      vecs[3] = '{1'b1, 20'h2AAAA, 19'h2AAAA, 1'b0};
      vecs[4] = '{1'b1, 20'h55555, 19'h55555, 1'b1};

      rst = 1'b1; tsel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; mdo = '0;
      step();
      step();
      chk("rst_so", so, 0);
      chk("rst_sel", msel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", mdin, 0);
      chk("rst_sel0", msel0, 0);
      rst = 1'b0;
      step();

      // Table: shift, update, check data/so, then confirm select stays functional.
      for (int v = 0; v < 5; v++) begin
         shift_word(vecs[v].ts, vecs[v].word);
         update(vecs[v].ts);
         chk($sformatf("vec%0d_data", v), mdin, vecs[v].exp_data);
         chk($sformatf("vec%0d_so", v), so, vecs[v].exp_so);
         step();
         chk($sformatf("vec%0d_sel", v), msel, 0);
         chk($sformatf("vec%0d_busy", v), busy, 0);
         $display("vec%0d ts=%0b word=%h data_in=%h so=%0b", v, vecs[v].ts, vecs[v].word, mdin, so);
      end

      // Test 1: reset in the middle of ARM_IJ takes effect without a clock edge.
      w = {1'b1, 19'h12345};
      shift_word(1'b1, w);
      update(1'b1);
      chk("t1_data", mdin, 19'h12345);
      step();
      chk("t1_armed_busy", busy, 1);
      chk("t1_armed_sel", msel, 0);
      #1 rst = 1'b1;
      #1;
      chk("t1_async_sel", msel, 0);
      chk("t1_async_busy", busy, 0);
      chk("t1_async_so", so, 0);
      chk("t1_async_data", mdin, 0);
      chk("t1_async_sel0", msel0, 0);
      $display("t1 async reset sel=%0b busy=%0b so=%0b data_in=%h", msel, busy, so, mdin);
      @(negedge tck);
      rst = 1'b0;
      step();

      // Test 2: switch to IJTAG with a 4-cycle settle; zero-delay instance switches next edge.
      w = {1'b1, 19'h5A5A5};
      shift_word(1'b1, w);
      update(1'b1);
      chk("t2_data", mdin, 19'h5A5A5);
      chk("t2_k_busy", busy, 0);
      chk("t2_k_sel", msel, 0);
      for (int j = 1; j <= 4; j++) begin
         step();
         chk($sformatf("t2_k%0d_busy", j), busy, 1);
         chk($sformatf("t2_k%0d_sel", j), msel, 0);
         if (j == 1) begin
            chk("t2_sel0", msel0, 1);
            chk("t2_busy0", busy0, 0);
         end
      end
      step();
      chk("t2_k5_sel", msel, 1);
      chk("t2_k5_busy", busy, 0);
      $display("t2 switch sel=%0b busy=%0b data_in=%h", msel, busy, mdin);

      // Test 3: capture in IJTAG then shift out LSB-first.
      mdo  = 19'h7FFFF;
      tsel = 1'b1;
      ce   = 1'b1;
      step();
      ce    = 1'b0;
      exp20 = 20'hFFFFF;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t3_so%0d", i), so, exp20[i]);
         se = 1'b1;
         si = 1'b0;
         step();
      end
      se = 1'b0;
      chk("t3_so_after", so, 0);
      $display("t3 capture/shift stream checked");

      // Test 4: return to FUNC, then request IJTAG and revert it while arming.
      shift_word(1'b1, 20'h00000);
      update(1'b1);
      repeat (5) step();
      chk("t4_func_sel", msel, 0);
      chk("t4_func_busy", busy, 0);
      w = {1'b1, 19'h00003};
      shift_word(1'b1, w);
      update(1'b1);
      mdo = 19'h1234F;
      ce  = 1'b1;
      step();
      ce = 1'b0;
      chk("t4_k1_busy", busy, 1);
      chk("t4_k1_sel", msel, 0);
      ue = 1'b1;
      step();
      ue = 1'b0;
      chk("t4_k2_busy", busy, 1);
      chk("t4_k2_sel", msel, 0);
      chk("t4_k2_data", mdin, 19'h1234F);
      for (int j = 3; j <= 8; j++) begin
         step();
         chk($sformatf("t4_k%0d_sel", j), msel, 0);
         chk($sformatf("t4_k%0d_busy", j), busy, 0);
      end
      $display("t4 abort sel=%0b busy=%0b data_in=%h", msel, busy, mdin);

      // Test 5: simultaneous enables -> capture only; deselected -> nothing moves.
      mdo  = 19'h0F0F0;
      tsel = 1'b1;
      ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
      step();
      chk("t5_cap_so", so, 0);
      chk("t5_cap_data", mdin, 19'h1234F);
      tsel = 1'b0;
      mdo  = 19'h7FFFF;
      step();
      chk("t5_desel_so", so, 0);
      chk("t5_desel_data", mdin, 19'h1234F);
      chk("t5_desel_sel", msel, 0);
      ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
      tsel  = 1'b1;
      exp20 = {1'b0, 19'h0F0F0};
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t5_so%0d", i), so, exp20[i]);
         se = 1'b1;
         step();
      end
      se = 1'b0;
      $display("t5 priority/deselect data_in=%h", mdin);

      chk("t6_busy0_never", busy0_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
